gsensor_spi_responder: RTL and testbench

// SPI mode-3 (CPOL=1, CPHA=1) 4-wire slave emulating the ADXL345-style G-sensor register interface.
// It is the far end of the accel SPI master and drives GSENSOR_SDO-equivalent data back to it.

---
 rtl/gsensor_spi_responder.sv | 172 +++++++++++++++++
 tb/tb_gsensor_spi_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gsensor_spi_responder.sv
// gsensor_spi_responder: ADXL345-style SPI mode-3 register slave; define GSENSOR_RESP_INT_EN for INT_ENABLE and int1_o.
module gsensor_spi_responder #(
    parameter logic [7:0] DEVID_VAL   = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    input  logic        spi_sclk_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_sdi_i,
    output logic        spi_sdo_o,
    output logic        spi_sdo_oe_o,
    output logic [7:0]  reg_power_ctl_o,
    output logic [7:0]  reg_data_format_o
`ifdef GSENSOR_RESP_INT_EN
    ,
    output logic        int1_o
`endif
);
    localparam int SM = SYNC_STAGES - 1;
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
    state_t state, state_nxt;
    logic [SM:0] sclk_s, cs_s, sdi_s;
    logic sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise, byte_end;
    logic in_frame, cmd_done, data_done, tx_fall;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sh, tx_sh;
    logic [7:0] rx_byte, rd_byte, bw_rate, int_en_rd;
    logic rw, mb, rd_hit, data_ready, sample_set;
    logic [5:0] addr;
    logic [5:0][7:0] snap;
    logic [15:0] x_r, y_r, z_r;
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sclk_s <= '1;
            cs_s   <= '1;
            sdi_s  <= '0;
            sclk_d <= 1'b1;
            cs_d   <= 1'b1;
        end else begin
            sclk_s <= {sclk_s[SM-1:0], spi_sclk_i};
            cs_s   <= {cs_s[SM-1:0], spi_cs_n_i};
            sdi_s  <= {sdi_s[SM-1:0], spi_sdi_i};
            sclk_d <= sclk_s[SM];
            cs_d   <= cs_s[SM];
        end
    end
    assign sclk_rise  = sclk_s[SM] & ~sclk_d;
    assign sclk_fall  = ~sclk_s[SM] & sclk_d;
    assign cs_fall    = ~cs_s[SM] & cs_d;
    assign cs_rise    = cs_s[SM] & ~cs_d;
    assign byte_end   = sclk_rise && bit_cnt == 3'd7;
    assign rx_byte    = {rx_sh, sdi_s[SM]};
    assign sample_set = sample_valid && reg_power_ctl_o[3];
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (cs_rise) state_nxt = IDLE;
        else if (state == IDLE && cs_fall) state_nxt = CMD;
        else if (state == CMD && byte_end) state_nxt = DATA;
    end
    always_comb begin
        in_frame  = state != IDLE;
        cmd_done  = state == CMD && byte_end && !cs_rise;
        data_done = state == DATA && byte_end && !cs_rise;
        tx_fall   = state == DATA && rw && sclk_fall && !cs_rise;
    end
`ifdef GSENSOR_RESP_INT_EN
    logic [7:0] int_enable;
    assign int_en_rd = int_enable;
`else
    assign int_en_rd = 8'h00;
`endif
    // Data registers read from the snapshot taken at CS_N fall so multi-byte reads stay coherent.
    always_comb begin
        case (addr)
            6'h00:   rd_byte = DEVID_VAL;
            6'h2C:   rd_byte = bw_rate;
            6'h2D:   rd_byte = reg_power_ctl_o;
            6'h2E:   rd_byte = int_en_rd;
            6'h30:   rd_byte = {data_ready, 7'b0};
            6'h31:   rd_byte = reg_data_format_o;
            6'h32, 6'h33, 6'h34, 6'h35, 6'h36, 6'h37: rd_byte = snap[addr[2:0] - 3'd2];
            default: rd_byte = 8'h00;
        endcase
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bit_cnt      <= '0;
            rx_sh        <= '0;
            tx_sh        <= '0;
            rw           <= 1'b0;
            mb           <= 1'b0;
            addr         <= '0;
            snap         <= '0;
            rd_hit       <= 1'b0;
            spi_sdo_o    <= 1'b0;
            spi_sdo_oe_o <= 1'b0;
        end else begin
            if (cs_fall) begin
                bit_cnt <= '0;
                snap    <= {z_r, y_r, x_r};
                rd_hit  <= 1'b0;
            end else if (in_frame && sclk_rise) begin
                rx_sh   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (cmd_done) {rw, mb, addr} <= rx_byte;
            if (data_done) begin
                addr   <= mb ? addr + 6'd1 : addr;
                rd_hit <= rd_hit | (rw && addr[5:3] == 3'b110 && addr[2:1] != 2'b00);
            end
            // bit_cnt is zero on the first fall of each byte: load a fresh byte there.
            if (tx_fall) begin
                spi_sdo_o    <= bit_cnt == 3'd0 ? rd_byte[7] : tx_sh[6];
                tx_sh        <= bit_cnt == 3'd0 ? rd_byte[6:0] : {tx_sh[5:0], 1'b0};
                spi_sdo_oe_o <= 1'b1;
            end
            if (cs_rise) begin
                spi_sdo_o    <= 1'b0;
                spi_sdo_oe_o <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bw_rate           <= BW_RATE_RST;
            reg_power_ctl_o   <= 8'h00;
            reg_data_format_o <= 8'h00;
`ifdef GSENSOR_RESP_INT_EN
            int_enable        <= 8'h00;
`endif
            x_r               <= '0;
            y_r               <= '0;
            z_r               <= '0;
            data_ready        <= 1'b0;
        end else begin
            if (data_done && !rw) begin
                case (addr)
                    6'h2C: bw_rate           <= rx_byte;
                    6'h2D: reg_power_ctl_o   <= rx_byte;
`ifdef GSENSOR_RESP_INT_EN
                    6'h2E: int_enable        <= rx_byte;
`endif
                    6'h31: reg_data_format_o <= rx_byte;
                    default: ;
                endcase
            end
            if (sample_set) begin
                x_r <= sample_x;
                y_r <= sample_y;
                z_r <= sample_z;
            end
            data_ready <= sample_set | (data_ready & ~(cs_rise & rd_hit));
        end
    end
`ifdef GSENSOR_RESP_INT_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) int1_o <= 1'b0;
        else         int1_o <= data_ready & int_enable[7];
    end
`endif
endmodule

// File: tb/tb_gsensor_spi_responder.sv
// tb_gsensor_spi_responder: directed SPI mode-3 transactions against gsensor_spi_responder with an expected-byte queue.
module tb_gsensor_spi_responder;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
    logic sample_valid = 1'b0;
    logic spi_sclk_i = 1'b1, spi_cs_n_i = 1'b1, spi_sdi_i = 1'b0;
    logic spi_sdo_o, spi_sdo_oe_o;
    logic [7:0] reg_power_ctl_o, reg_data_format_o;
`ifdef GSENSOR_RESP_INT_EN
    logic int1_o;
`endif
    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    always #20 clk = ~clk;

    gsensor_spi_responder dut (
        .clk(clk),
        .arst_n(arst_n),
        .sample_x(sample_x),
        .sample_y(sample_y),
        .sample_z(sample_z),
        .sample_valid(sample_valid),
        .spi_sclk_i(spi_sclk_i),
        .spi_cs_n_i(spi_cs_n_i),
        .spi_sdi_i(spi_sdi_i),
        .spi_sdo_o(spi_sdo_o),
        .spi_sdo_oe_o(spi_sdo_oe_o),
        .reg_power_ctl_o(reg_power_ctl_o),
        .reg_data_format_o(reg_data_format_o)
`ifdef GSENSOR_RESP_INT_EN
        ,
        .int1_o(int1_o)
`endif
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic oe_any);
        rx = '0;
        oe_any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            spi_sclk_i = 1'b0;
            spi_sdi_i = tx[i];
            #250;
            rx[i] = spi_sdo_o;
            oe_any = oe_any | spi_sdo_oe_o;
            spi_sclk_i = 1'b1;
            #250;
        end
    endtask

    task automatic cs_low();
        spi_cs_n_i = 1'b0;
        #300;
    endtask

    task automatic cs_high();
        #300;
        spi_cs_n_i = 1'b1;
        #300;
    endtask

    task automatic read_tx(input string tag, input logic [7:0] cmd, input int n);
        logic [7:0] rx;
        logic oe;
        cs_low();
        xfer(cmd, rx, oe);
        check({tag, " cmd_oe"}, 16'(oe), 16'd0);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, rx, oe);
            check({tag, " data"}, 16'(rx), 16'(exp_q.pop_front()));
            check({tag, " data_oe"}, 16'(oe), 16'd1);
        end
        cs_high();
        check({tag, " idle_oe"}, 16'(spi_sdo_oe_o), 16'd0);
        check({tag, " idle_sdo"}, 16'(spi_sdo_o), 16'd0);
    endtask

    task automatic write_tx(input logic [7:0] cmd, input logic [7:0] d);
        logic [7:0] rx;
        logic oe;
        cs_low();
        xfer(cmd, rx, oe);
        xfer(d, rx, oe);
        cs_high();
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        sample_x = x;
        sample_y = y;
        sample_z = z;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] rx;
        logic oe;
        #100;
        check("rst_oe", 16'(spi_sdo_oe_o), 16'd0);
        check("rst_sdo", 16'(spi_sdo_o), 16'd0);
        check("rst_power_ctl", 16'(reg_power_ctl_o), 16'h00);
        check("rst_data_format", 16'(reg_data_format_o), 16'h00);
`ifdef GSENSOR_RESP_INT_EN
        check("rst_int1", 16'(int1_o), 16'd0);
`endif
        @(negedge clk);
        arst_n = 1'b1;
        #200;

        exp_q.push_back(8'hE5);
        read_tx("devid", 8'h80, 1);

        write_tx(8'h2D, 8'h08);
        check("power_ctl_wr", 16'(reg_power_ctl_o), 16'h08);
        exp_q.push_back(8'h08);
        read_tx("power_ctl_rd", 8'hAD, 1);

        write_tx(8'h00, 8'h55);
        exp_q.push_back(8'hE5);
        read_tx("devid_ro", 8'h80, 1);

        exp_q.push_back(8'h0A);
        read_tx("bw_rate_rst", 8'hAC, 1);

        pulse_sample(16'h0123, 16'hFFC0, 16'h0100);
        exp_q.push_back(8'h80);
        read_tx("int_src_set", 8'hB0, 1);
        exp_q.push_back(8'h23);
        exp_q.push_back(8'h23);
        read_tx("mb0_same_addr", 8'hB2, 2);
        exp_q.push_back(8'h00);
        read_tx("int_src_clr", 8'hB0, 1);

        // Coherent burst with a new sample landing after the second byte.
        pulse_sample(16'h0123, 16'hFFC0, 16'h0100);
        exp_q.push_back(8'h23);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        cs_low();
        xfer(8'hF2, rx, oe);
        check("burst cmd_oe", 16'(oe), 16'd0);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) pulse_sample(16'h4567, 16'h89AB, 16'hCDEF);
            xfer(8'h00, rx, oe);
            check("burst data", 16'(rx), 16'(exp_q.pop_front()));
        end
        cs_high();
        check("burst idle_oe", 16'(spi_sdo_oe_o), 16'd0);
        exp_q.push_back(8'h67);
        read_tx("live_x0", 8'hB2, 1);
        exp_q.push_back(8'hCD);
        read_tx("live_z1", 8'hB7, 1);

        cs_low();
        xfer(8'h31, rx, oe);
        for (int i = 0; i < 4; i++) begin
            spi_sclk_i = 1'b0;
            spi_sdi_i = 1'b1;
            #250;
            spi_sclk_i = 1'b1;
            #250;
        end
        cs_high();
        check("abort_data_format", 16'(reg_data_format_o), 16'h00);
        write_tx(8'h31, 8'h0B);
        check("data_format_wr", 16'(reg_data_format_o), 16'h0B);
        exp_q.push_back(8'h0B);
        read_tx("data_format_rd", 8'hB1, 1);

        exp_q.push_back(8'h00);
        exp_q.push_back(8'hE5);
        read_tx("wrap", 8'hFF, 2);

`ifdef GSENSOR_RESP_INT_EN
        write_tx(8'h2E, 8'h80);
        check("int1_idle", 16'(int1_o), 16'd0);
        pulse_sample(16'h1111, 16'h2222, 16'h3333);
        repeat (3) @(negedge clk);
        check("int1_set", 16'(int1_o), 16'd1);
        exp_q.push_back(8'h11);
        read_tx("int1_read", 8'hB2, 1);
        repeat (3) @(negedge clk);
        check("int1_clr", 16'(int1_o), 16'd0);
`else
        write_tx(8'h2E, 8'h80);
        exp_q.push_back(8'h00);
        read_tx("int_en_absent", 8'hAE, 1);
`endif

        cs_low();
        xfer(8'h80, rx, oe);
        spi_sclk_i = 1'b0;
        #250;
        check("pre_rst_oe", 16'(spi_sdo_oe_o), 16'd1);
        arst_n = 1'b0;
        #1;
        check("mid_rst_oe", 16'(spi_sdo_oe_o), 16'd0);
        check("mid_rst_sdo", 16'(spi_sdo_o), 16'd0);
        check("mid_rst_power_ctl", 16'(reg_power_ctl_o), 16'h00);
        spi_sclk_i = 1'b1;
        spi_cs_n_i = 1'b1;
        #200;
        arst_n = 1'b1;
        #300;
        exp_q.push_back(8'hE5);
        read_tx("post_rst", 8'h80, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
